mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer.sv | 146 ++++++++++++++
 tb/tb_mul_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative signed shift-add multiplier that takes over the MUL opcode beside the ALU.
// Latency: WIDTH+1 cycles from the issue cycle to the one-cycle MulDone strobe; one MUL every WIDTH+2 cycles.
// Backpressure: Stall is held combinationally from the issue cycle through the last RUN cycle; Flush aborts silently.
module mul_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             MulStart,
   input  logic             Flush,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Stall,
   output logic             MulDone,
   output logic [WIDTH-1:0] MulResult,
   output logic [WIDTH-1:0] MulHi
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Operand magnitudes, step counter and the running 2*WIDTH accumulator.
   logic [CW-1:0]        count;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic                 sign;

   // Control strobes decoded by the FSM.
   logic start;
   logic step;
   logic finish;

   // Datapath combinational values.
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_step;
   logic [2*WIDTH-1:0]   product;
   logic                 unused_acc_lsb;

   // Magnitudes are taken as unsigned WIDTH-bit values so that |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
   assign mag_a = SrcA[WIDTH-1] ? ({WIDTH{1'b0}} - SrcA) : SrcA;
   assign mag_b = SrcB[WIDTH-1] ? ({WIDTH{1'b0}} - SrcB) : SrcB;

   // One shift-add step: conditional add into the upper half with the carry kept, then shift right.
   assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mplier[0]}}};
   assign acc_step = {sum, acc[WIDTH-1:1]};

   // The accumulator LSB falls off the bottom every step and is never needed again.
   assign unused_acc_lsb = acc[0];

   // The final step's result is corrected for sign on the same edge that enters DONE.
   assign product = sign ? ({(2*WIDTH){1'b0}} - acc_step) : acc_step;

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus the combinational Stall/MulDone outputs.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      Stall     = 1'b0;
      MulDone   = 1'b0;
      case (state)
         IDLE: begin
            // Flush wins over a simultaneous start.
            if (MulStart && !Flush) begin
               start     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (Flush) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (count == LAST) begin
                  finish    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            // The MUL retires this cycle; MulStart and Flush are both ignored here.
            MulDone   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Stall covers the issue cycle and every RUN cycle, and is forced low while in reset.
      Stall = RST & (start | step);
   end

   // Operand capture and the iterative shift-add datapath.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         sign   <= 1'b0;
      end else if (start) begin
         count  <= '0;
         mcand  <= mag_a;
         mplier <= mag_b;
         acc    <= '0;
         sign   <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
      end else if (step) begin
         count  <= count + CW'(1);
         mplier <= mplier >> 1;
         acc    <= acc_step;
      end
   end

   // Result registers load only on entry to DONE and otherwise hold across flushes.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         MulResult <= '0;
         MulHi     <= '0;
      end else if (finish) begin
         MulResult <= product[WIDTH-1:0];
         MulHi     <= product[2*WIDTH-1:WIDTH];
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for the iterative MUL sequencer.
// Expected products come from a native 64-bit signed multiply pushed at issue time.
// Outputs are sampled 1 ns after the rising edge; inputs are driven at the same point.
module tb_mul_sequencer;

   localparam int W = 32;

   logic         CLK      = 1'b0;
   logic         RST      = 1'b0;
   logic         MulStart = 1'b0;
   logic         Flush    = 1'b0;
   logic [W-1:0] SrcA     = '0;
   logic [W-1:0] SrcB     = '0;
   logic         Stall;
   logic         MulDone;
   logic [W-1:0] MulResult;
   logic [W-1:0] MulHi;

   int vectors     = 0;
   int miscompares = 0;

   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   last_hi = '0;
   logic [W-1:0]   last_lo = '0;

   mul_sequencer #(.WIDTH(W)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .MulStart (MulStart),
      .Flush    (Flush),
      .SrcA     (SrcA),
      .SrcB     (SrcB),
      .Stall    (Stall),
      .MulDone  (MulDone),
      .MulResult(MulResult),
      .MulHi    (MulHi)
   );

   always #5 CLK = ~CLK;

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drive one issue cycle (cycle 0), then drop MulStart once in cycle 1.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
      SrcA     = a;
      SrcB     = b;
      MulStart = 1'b1;
      if (expect_result) exp_q.push_back(model(a, b));
      #1;
      vectors++;
      if (Stall !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_stall a=%h b=%h got=%b want=1", a, b, Stall);
      end
      tick();
      MulStart = 1'b0;
   endtask

   // Called in cycle 1; returns in the cycle MulDone is seen, or after the budget expires.
   task automatic wait_done(input int budget, output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      for (int c = 1; c <= budget; c++) begin
         if (MulDone === 1'b1) begin
            seen   = 1'b1;
            cycles = c;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      RST      = 1'b0;
      MulStart = 1'b1;
      SrcA     = 32'd3;
      SrcB     = 32'd3;
      #3;
      vectors++;
      if (Stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b want=0", Stall); end
      vectors++;
      if (MulDone !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", MulDone); end
      vectors++;
      if (MulResult !== '0) begin miscompares++; $display("FAIL reset_lo got=%h want=0", MulResult); end
      vectors++;
      if (MulHi !== '0) begin miscompares++; $display("FAIL reset_hi got=%h want=0", MulHi); end
      tick();
      vectors++;
      if (Stall !== 1'b0 || MulDone !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_held stall=%b done=%b want=0/0", Stall, MulDone);
      end
      MulStart = 1'b0;
      #2;
      RST = 1'b1;
      tick();
      vectors++;
      if (Stall !== 1'b0 || MulDone !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release stall=%b done=%b want=0/0", Stall, MulDone);
      end
   endtask

   // 7 x 6 with MulStart held high through DONE.
   task automatic test_basic();
      logic [2*W-1:0] e;
      SrcA     = 32'd7;
      SrcB     = 32'd6;
      MulStart = 1'b1;
      exp_q.push_back(model(32'd7, 32'd6));
      #1;
      vectors++;
      if (Stall !== 1'b1) begin miscompares++; $display("FAIL basic_c0_stall got=%b want=1", Stall); end
      for (int c = 1; c <= 32; c++) begin
         tick();
         vectors++;
         if (Stall !== 1'b1 || MulDone !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run cycle=%0d stall=%b done=%b want=1/0", c, Stall, MulDone);
         end
      end
      tick();
      vectors++;
      if (MulDone !== 1'b1 || Stall !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_c33 done=%b stall=%b want=1/0", MulDone, Stall);
      end
      e = exp_q.pop_front();
      vectors++;
      if ({MulHi, MulResult} !== e || MulResult !== 32'd42) begin
         miscompares++;
         $display("FAIL basic_product got=%h_%h want=%h", MulHi, MulResult, e);
      end
      last_hi  = e[2*W-1:W];
      last_lo  = e[W-1:0];
      MulStart = 1'b0;
      tick();
      vectors++;
      if (MulDone !== 1'b0 || Stall !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_c34 done=%b stall=%b want=0/0", MulDone, Stall);
      end
   endtask

   // Signed corner cases plus a few random operand pairs.
   task automatic test_signed();
      logic [W-1:0]   ta[10];
      logic [W-1:0]   tb[10];
      logic [2*W-1:0] e;
      int             cyc;
      bit             seen;
      ta[0] = 32'hFFFF_FFFD; tb[0] = 32'h0000_0005;
      ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000;
      ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;
      ta[3] = 32'h0000_0000; tb[3] = 32'h0001_2345;
      ta[4] = 32'hFFFF_FFFF; tb[4] = 32'hFFFF_FFFF;
      ta[5] = 32'h7FFF_FFFF; tb[5] = 32'h8000_0000;
      for (int i = 6; i < 10; i++) begin
         ta[i] = $urandom;
         tb[i] = $urandom;
      end
      for (int i = 0; i < 10; i++) begin
         issue(ta[i], tb[i], 1'b1);
         wait_done(40, cyc, seen);
         vectors++;
         if (!seen || cyc != 33) begin
            miscompares++;
            $display("FAIL signed_latency idx=%0d seen=%b cycle=%0d want=33", i, seen, cyc);
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            vectors++;
            if ({MulHi, MulResult} !== e) begin
               miscompares++;
               $display("FAIL signed_product a=%h b=%h got=%h_%h want=%h", ta[i], tb[i], MulHi, MulResult, e);
            end
            last_hi = e[2*W-1:W];
            last_lo = e[W-1:0];
         end
         tick();
      end
   endtask

   // Operands wiggle every RUN cycle; then a back-to-back MUL issued in cycle 34.
   task automatic test_back_to_back();
      logic [2*W-1:0] e;
      int             cyc;
      bit             seen;
      issue(32'h0001_0000, 32'h0001_0000, 1'b1);
      seen = 1'b0;
      cyc  = 0;
      for (int c = 1; c <= 40; c++) begin
         if (MulDone === 1'b1) begin
            seen = 1'b1;
            cyc  = c;
            break;
         end
         SrcA = $urandom;
         SrcB = $urandom;
         tick();
      end
      vectors++;
      if (!seen || cyc != 33) begin
         miscompares++;
         $display("FAIL b2b_first_latency seen=%b cycle=%0d want=33", seen, cyc);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (MulHi !== 32'd1 || MulResult !== 32'd0 || {MulHi, MulResult} !== e) begin
            miscompares++;
            $display("FAIL b2b_first_product got=%h_%h want=%h", MulHi, MulResult, e);
         end
      end
      tick();
      issue(32'd2, 32'd3, 1'b1);
      wait_done(40, cyc, seen);
      vectors++;
      if (!seen || cyc != 33) begin
         miscompares++;
         $display("FAIL b2b_second_latency seen=%b cycle=%0d want=33", seen, cyc);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({MulHi, MulResult} !== e || MulResult !== 32'd6) begin
            miscompares++;
            $display("FAIL b2b_second_product got=%h_%h want=%h", MulHi, MulResult, e);
         end
         last_hi = e[2*W-1:W];
         last_lo = e[W-1:0];
      end
      tick();
   endtask

   // Flush in RUN cycle 10, then Flush colliding with a start in IDLE.
   task automatic test_flush();
      logic [2*W-1:0] e;
      int             cyc;
      int             dones;
      bit             seen;
      issue(32'd5, 32'd5, 1'b0);
      repeat (9) tick();
      Flush = 1'b1;
      #1;
      vectors++;
      if (Stall !== 1'b0) begin miscompares++; $display("FAIL flush_c10_stall got=%b want=0", Stall); end
      tick();
      Flush = 1'b0;
      vectors++;
      if (Stall !== 1'b0 || MulDone !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_c11 stall=%b done=%b want=0/0", Stall, MulDone);
      end
      vectors++;
      if (MulResult !== last_lo || MulHi !== last_hi) begin
         miscompares++;
         $display("FAIL flush_hold got=%h_%h want=%h_%h", MulHi, MulResult, last_hi, last_lo);
      end
      // A fresh MUL right away proves the block is back in IDLE.
      issue(32'hFFFF_FFFC, 32'd4, 1'b1);
      wait_done(40, cyc, seen);
      vectors++;
      if (!seen || cyc != 33) begin
         miscompares++;
         $display("FAIL flush_restart_latency seen=%b cycle=%0d want=33", seen, cyc);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({MulHi, MulResult} !== e) begin
            miscompares++;
            $display("FAIL flush_restart_product got=%h_%h want=%h", MulHi, MulResult, e);
         end
         last_hi = e[2*W-1:W];
         last_lo = e[W-1:0];
      end
      tick();
      MulStart = 1'b1;
      Flush    = 1'b1;
      SrcA     = 32'd11;
      SrcB     = 32'd11;
      #1;
      vectors++;
      if (Stall !== 1'b0) begin miscompares++; $display("FAIL flush_idle_stall got=%b want=0", Stall); end
      tick();
      MulStart = 1'b0;
      Flush    = 1'b0;
      dones    = 0;
      for (int c = 0; c < 40; c++) begin
         if (MulDone === 1'b1 || Stall === 1'b1) dones++;
         tick();
      end
      vectors++;
      if (dones != 0) begin miscompares++; $display("FAIL flush_idle_activity got=%0d want=0", dones); end
      vectors++;
      if (MulResult !== last_lo || MulHi !== last_hi) begin
         miscompares++;
         $display("FAIL flush_idle_hold got=%h_%h want=%h_%h", MulHi, MulResult, last_hi, last_lo);
      end
   endtask

   // Reset asserted in RUN cycle 20, then 9 x 9 from the first edge after release.
   task automatic test_reset_mid_run();
      logic [2*W-1:0] e;
      int             cyc;
      bit             seen;
      issue(32'h0000_1234, 32'h0000_5678, 1'b0);
      repeat (19) tick();
      RST      = 1'b0;
      MulStart = 1'b1;
      #1;
      vectors++;
      if (Stall !== 1'b0 || MulDone !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_ctrl stall=%b done=%b want=0/0", Stall, MulDone);
      end
      vectors++;
      if (MulResult !== '0 || MulHi !== '0) begin
         miscompares++;
         $display("FAIL midrst_outputs got=%h_%h want=0_0", MulHi, MulResult);
      end
      tick();
      RST = 1'b1;
      issue(32'd9, 32'd9, 1'b1);
      wait_done(40, cyc, seen);
      vectors++;
      if (!seen || cyc != 33) begin
         miscompares++;
         $display("FAIL midrst_latency seen=%b cycle=%0d want=33", seen, cyc);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({MulHi, MulResult} !== e || MulResult !== 32'd81) begin
            miscompares++;
            $display("FAIL midrst_product got=%h_%h want=%h", MulHi, MulResult, e);
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_back_to_back();
      test_flush();
      test_reset_mid_run();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
